// File: rtl/id_stage_pipelined.sv
// id_stage_pipelined: MIPS instruction-decode stage.
//
// Holds the register file (write-through bypass), resolves branches and jumps in ID,
// detects load-use hazards and registers the decoded instruction into an ID/EX bank
// that carries a valid bit. The debug unit can freeze the stage and read registers.
//
// Ports:
//   clk, reset (async, active-low)
//   i_valid, i_instruction, i_pc_next, i_ctl   IF/ID contents and control decode
//   i_ex_mem_read, i_ex_rt_addr                load in EX (load-use detection)
//   i_wb_wr_ena, i_wb_addr, i_wb_data          register-file write port
//   i_du_halt, i_du_addr, o_du_data            debug freeze and register read
//   o_stall, o_pc_sel, o_pc_target, o_flush    combinational fetch control
//   o_valid .. o_funct                         registered ID/EX bank
//
// Optional build macro ID_BRANCH_FWD_EN: adds MEM-stage forwarding into the branch/jump
// comparator (i_mem_*) and a one-cycle stall when the branch depends on the EX result
// (i_ex_wr_ena, i_ex_rd_addr). Without it the comparator uses register-file values only.
module id_stage_pipelined #(
  parameter int unsigned NB_DATA  = 32,
  parameter int unsigned NB_PC    = 32,
  parameter int unsigned NB_RADDR = 5,
  parameter int unsigned LINK_REG = 31
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_valid,
  input  logic [31:0]         i_instruction,
  input  logic [NB_PC-1:0]    i_pc_next,
  input  logic [5:0]          i_ctl,
  input  logic                i_ex_mem_read,
  input  logic [NB_RADDR-1:0] i_ex_rt_addr,
  input  logic                i_wb_wr_ena,
  input  logic [NB_RADDR-1:0] i_wb_addr,
  input  logic [NB_DATA-1:0]  i_wb_data,
  input  logic                i_du_halt,
  input  logic [NB_RADDR-1:0] i_du_addr,
`ifdef ID_BRANCH_FWD_EN
  input  logic                i_mem_wr_ena,
  input  logic [NB_RADDR-1:0] i_mem_rd_addr,
  input  logic [NB_DATA-1:0]  i_mem_data,
  input  logic                i_ex_wr_ena,
  input  logic [NB_RADDR-1:0] i_ex_rd_addr,
`endif
  output logic [NB_DATA-1:0]  o_du_data,
  output logic                o_stall,
  output logic                o_pc_sel,
  output logic [NB_PC-1:0]    o_pc_target,
  output logic                o_flush,
  output logic                o_valid,
  output logic [NB_DATA-1:0]  o_rs_data,
  output logic [NB_DATA-1:0]  o_rt_data,
  output logic [NB_DATA-1:0]  o_imm,
  output logic [NB_RADDR-1:0] o_rs_addr,
  output logic [NB_RADDR-1:0] o_rt_addr,
  output logic [NB_RADDR-1:0] o_rd_addr,
  output logic [5:0]          o_opcode,
  output logic [5:0]          o_funct
);

  localparam int unsigned NREGS = 2 ** NB_RADDR;

  // i_ctl bit positions
  localparam int unsigned CtlBeq  = 0;
  localparam int unsigned CtlBne  = 1;
  localparam int unsigned CtlJ    = 2;
  localparam int unsigned CtlJal  = 3;
  localparam int unsigned CtlJr   = 4;
  localparam int unsigned CtlJalr = 5;

  // Instruction fields
  logic [5:0]          opcode;
  logic [5:0]          funct;
  logic [15:0]         imm16;
  logic [NB_RADDR-1:0] rs_addr;
  logic [NB_RADDR-1:0] rt_addr;
  logic [NB_RADDR-1:0] rd_field;

  assign opcode   = i_instruction[31:26];
  assign funct    = i_instruction[5:0];
  assign imm16    = i_instruction[15:0];
  assign rs_addr  = NB_RADDR'(i_instruction[25:21]);
  assign rt_addr  = NB_RADDR'(i_instruction[20:16]);
  assign rd_field = NB_RADDR'(i_instruction[15:11]);

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [NB_DATA-1:0] rf_q [NREGS];
  logic               rf_wr;

  // Halt gates both the write and the bypass, so debug reads see stable state.
  assign rf_wr = i_wb_wr_ena && !i_du_halt && (i_wb_addr != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (rf_wr) begin
      rf_q[i_wb_addr] <= i_wb_data;
    end
  end

  function automatic logic [NB_DATA-1:0] rf_read(input logic [NB_RADDR-1:0] addr);
    if (addr == '0) begin
      return '0;
    end
    if (rf_wr && (i_wb_addr == addr)) begin
      return i_wb_data;
    end
    return rf_q[addr];
  endfunction

  logic [NB_DATA-1:0] rs_data;
  logic [NB_DATA-1:0] rt_data;

  assign rs_data   = rf_read(rs_addr);
  assign rt_data   = rf_read(rt_addr);
  assign o_du_data = rf_read(i_du_addr);

  // ---------------------------------------------------------------------------
  // Hazard detection and comparator operands
  // ---------------------------------------------------------------------------
  logic               load_use;
  logic [NB_DATA-1:0] br_rs;
  logic [NB_DATA-1:0] br_rt;

  assign load_use = i_valid && i_ex_mem_read && (i_ex_rt_addr != '0) &&
                    ((i_ex_rt_addr == rs_addr) || (i_ex_rt_addr == rt_addr));

`ifdef ID_BRANCH_FWD_EN
  logic uses_cmp;
  logic br_hazard;

  assign br_rs = (i_mem_wr_ena && (i_mem_rd_addr != '0) && (i_mem_rd_addr == rs_addr)) ?
                 i_mem_data : rs_data;
  assign br_rt = (i_mem_wr_ena && (i_mem_rd_addr != '0) && (i_mem_rd_addr == rt_addr)) ?
                 i_mem_data : rt_data;

  // Branch operands are needed in ID, so an ALU result still in EX cannot reach them.
  assign uses_cmp  = i_ctl[CtlBeq] | i_ctl[CtlBne] | i_ctl[CtlJr] | i_ctl[CtlJalr];
  assign br_hazard = i_valid && uses_cmp && i_ex_wr_ena && (i_ex_rd_addr != '0) &&
                     ((i_ex_rd_addr == rs_addr) || (i_ex_rd_addr == rt_addr));
  assign o_stall   = (load_use || br_hazard) && !i_du_halt;
`else
  assign br_rs   = rs_data;
  assign br_rt   = rt_data;
  assign o_stall = load_use && !i_du_halt;
`endif

  // ---------------------------------------------------------------------------
  // Branch / jump resolution
  // ---------------------------------------------------------------------------
  logic [NB_PC-1:0] imm_pc;
  logic [NB_PC-1:0] br_tgt;
  logic [NB_PC-1:0] j_tgt;
  logic             resolve;
  logic             br_eq;

  assign imm_pc  = {{(NB_PC - 16){imm16[15]}}, imm16};
  assign br_tgt  = i_pc_next + (imm_pc << 2);
  assign resolve = i_valid && !o_stall && !i_du_halt;
  assign br_eq   = (br_rs == br_rt);

  always_comb begin
    j_tgt       = i_pc_next;
    j_tgt[27:0] = {i_instruction[25:0], 2'b00};
  end

  always_comb begin
    o_pc_sel    = 1'b0;
    o_pc_target = '0;
    if (resolve) begin
      if (i_ctl[CtlJr] || i_ctl[CtlJalr]) begin
        o_pc_sel    = 1'b1;
        o_pc_target = NB_PC'(br_rs);
      end else if (i_ctl[CtlJ] || i_ctl[CtlJal]) begin
        o_pc_sel    = 1'b1;
        o_pc_target = j_tgt;
      end else if ((i_ctl[CtlBeq] && br_eq) || (i_ctl[CtlBne] && !br_eq)) begin
        o_pc_sel    = 1'b1;
        o_pc_target = br_tgt;
      end
    end
  end

  assign o_flush = o_pc_sel;

  // ---------------------------------------------------------------------------
  // ID/EX bank
  // ---------------------------------------------------------------------------
  logic [NB_PC-1:0]    pc_link;
  logic [NB_DATA-1:0]  link_val;
  logic                is_link;

  assign pc_link  = i_pc_next + NB_PC'(4);
  assign link_val = NB_DATA'(pc_link);
  assign is_link  = i_ctl[CtlJal] | i_ctl[CtlJalr];

  logic                valid_q, valid_d;
  logic [NB_DATA-1:0]  rs_data_q, rs_data_d;
  logic [NB_DATA-1:0]  rt_data_q, rt_data_d;
  logic [NB_DATA-1:0]  imm_q, imm_d;
  logic [NB_RADDR-1:0] rs_addr_q, rs_addr_d;
  logic [NB_RADDR-1:0] rt_addr_q, rt_addr_d;
  logic [NB_RADDR-1:0] rd_addr_q, rd_addr_d;
  logic [5:0]          opcode_q, opcode_d;
  logic [5:0]          funct_q, funct_d;

  always_comb begin
    valid_d   = valid_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    rs_addr_d = rs_addr_q;
    rt_addr_d = rt_addr_q;
    rd_addr_d = rd_addr_q;
    opcode_d  = opcode_q;
    funct_d   = funct_q;
    if (!i_du_halt) begin
      if (o_stall) begin
        valid_d   = 1'b0;
        rs_data_d = '0;
        rt_data_d = '0;
        imm_d     = '0;
        rs_addr_d = '0;
        rt_addr_d = '0;
        rd_addr_d = '0;
        opcode_d  = '0;
        funct_d   = '0;
      end else begin
        valid_d   = i_valid;
        rs_data_d = rs_data;
        rt_data_d = is_link ? link_val : rt_data;
        imm_d     = {{(NB_DATA - 16){imm16[15]}}, imm16};
        rs_addr_d = rs_addr;
        rt_addr_d = rt_addr;
        rd_addr_d = i_ctl[CtlJal] ? NB_RADDR'(LINK_REG) : rd_field;
        opcode_d  = opcode;
        funct_d   = funct;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      rd_addr_q <= '0;
      opcode_q  <= '0;
      funct_q   <= '0;
    end else begin
      valid_q   <= valid_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_addr_q <= rs_addr_d;
      rt_addr_q <= rt_addr_d;
      rd_addr_q <= rd_addr_d;
      opcode_q  <= opcode_d;
      funct_q   <= funct_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_rs_data = rs_data_q;
  assign o_rt_data = rt_data_q;
  assign o_imm     = imm_q;
  assign o_rs_addr = rs_addr_q;
  assign o_rt_addr = rt_addr_q;
  assign o_rd_addr = rd_addr_q;
  assign o_opcode  = opcode_q;
  assign o_funct   = funct_q;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Directed bench for id_stage_pipelined (default parameters).
module tb_id_stage_pipelined;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid;
  logic [31:0] i_instruction;
  logic [31:0] i_pc_next;
  logic [5:0]  i_ctl;
  logic        i_ex_mem_read;
  logic [4:0]  i_ex_rt_addr;
  logic        i_wb_wr_ena;
  logic [4:0]  i_wb_addr;
  logic [31:0] i_wb_data;
  logic        i_du_halt;
  logic [4:0]  i_du_addr;
`ifdef ID_BRANCH_FWD_EN
  logic        i_mem_wr_ena;
  logic [4:0]  i_mem_rd_addr;
  logic [31:0] i_mem_data;
  logic        i_ex_wr_ena;
  logic [4:0]  i_ex_rd_addr;
`endif
  logic [31:0] o_du_data;
  logic        o_stall;
  logic        o_pc_sel;
  logic [31:0] o_pc_target;
  logic        o_flush;
  logic        o_valid;
  logic [31:0] o_rs_data;
  logic [31:0] o_rt_data;
  logic [31:0] o_imm;
  logic [4:0]  o_rs_addr;
  logic [4:0]  o_rt_addr;
  logic [4:0]  o_rd_addr;
  logic [5:0]  o_opcode;
  logic [5:0]  o_funct;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  id_stage_pipelined dut (
    .clk           (clk),
    .reset         (reset),
    .i_valid       (i_valid),
    .i_instruction (i_instruction),
    .i_pc_next     (i_pc_next),
    .i_ctl         (i_ctl),
    .i_ex_mem_read (i_ex_mem_read),
    .i_ex_rt_addr  (i_ex_rt_addr),
    .i_wb_wr_ena   (i_wb_wr_ena),
    .i_wb_addr     (i_wb_addr),
    .i_wb_data     (i_wb_data),
    .i_du_halt     (i_du_halt),
    .i_du_addr     (i_du_addr),
`ifdef ID_BRANCH_FWD_EN
    .i_mem_wr_ena  (i_mem_wr_ena),
    .i_mem_rd_addr (i_mem_rd_addr),
    .i_mem_data    (i_mem_data),
    .i_ex_wr_ena   (i_ex_wr_ena),
    .i_ex_rd_addr  (i_ex_rd_addr),
`endif
    .o_du_data     (o_du_data),
    .o_stall       (o_stall),
    .o_pc_sel      (o_pc_sel),
    .o_pc_target   (o_pc_target),
    .o_flush       (o_flush),
    .o_valid       (o_valid),
    .o_rs_data     (o_rs_data),
    .o_rt_data     (o_rt_data),
    .o_imm         (o_imm),
    .o_rs_addr     (o_rs_addr),
    .o_rt_addr     (o_rt_addr),
    .o_rd_addr     (o_rd_addr),
    .o_opcode      (o_opcode),
    .o_funct       (o_funct)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_type(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction

  task automatic wb(input logic [4:0] addr, input logic [31:0] data);
    i_wb_wr_ena = 1'b1;
    i_wb_addr   = addr;
    i_wb_data   = data;
    tick();
    i_wb_wr_ena = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    i_valid = 1'b0; i_instruction = '0; i_pc_next = '0; i_ctl = '0;
    i_ex_mem_read = 1'b0; i_ex_rt_addr = '0;
    i_wb_wr_ena = 1'b0; i_wb_addr = '0; i_wb_data = '0;
    i_du_halt = 1'b0; i_du_addr = '0;
`ifdef ID_BRANCH_FWD_EN
    i_mem_wr_ena = 1'b0; i_mem_rd_addr = '0; i_mem_data = '0;
    i_ex_wr_ena = 1'b0; i_ex_rd_addr = '0;
`endif
    #1 reset = 1'b0;
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_rd_addr", o_rd_addr, 0);
    chk("rst_stall", o_stall, 0);
    chk("rst_pc_sel", o_pc_sel, 0);
    #5 reset = 1'b1;
    tick();
    chk("rst_rs_data", o_rs_data, 0);

    // Preload registers
    wb(5'd1, 32'd7);
    wb(5'd2, 32'd7);
    wb(5'd5, 32'h55);
    wb(5'd6, 32'h2000);
    wb(5'd7, 32'h77);
    i_du_addr = 5'd5; #1;
    chk("rf_r5", o_du_data, 32'h55);

    // Write-through bypass: add r4,r3,r3 while r3 is written
    i_instruction = r_type(5'd3, 5'd3, 5'd4, 6'h20);
    i_valid = 1'b1;
    i_wb_wr_ena = 1'b1; i_wb_addr = 5'd3; i_wb_data = 32'hDEADBEEF;
    i_du_addr = 5'd3; #1;
    chk("bypass_du", o_du_data, 32'hDEADBEEF);
    tick();
    i_wb_wr_ena = 1'b0;
    chk("bypass_valid", o_valid, 1);
    chk("bypass_rs", o_rs_data, 32'hDEADBEEF);
    chk("bypass_rt", o_rt_data, 32'hDEADBEEF);
    chk("bypass_rd", o_rd_addr, 4);
    chk("bypass_rs_addr", o_rs_addr, 3);
    chk("bypass_funct", o_funct, 6'h20);

    // r0 is never written and never bypassed
    i_valid = 1'b0;
    i_wb_wr_ena = 1'b1; i_wb_addr = 5'd0; i_wb_data = 32'h1234;
    i_du_addr = 5'd0; #1;
    chk("r0_bypass", o_du_data, 0);
    tick();
    i_wb_wr_ena = 1'b0; #1;
    chk("r0_after", o_du_data, 0);

    // Load-use stall: add r5,r2,r1 with a load to r2 in EX
    i_instruction = r_type(5'd2, 5'd1, 5'd5, 6'h20);
    i_valid = 1'b1;
    i_ex_mem_read = 1'b1; i_ex_rt_addr = 5'd2; #1;
    chk("lu_stall", o_stall, 1);
    tick();
    chk("lu_bubble_valid", o_valid, 0);
    chk("lu_bubble_rd", o_rd_addr, 0);
    i_ex_mem_read = 1'b0; #1;
    chk("lu_release", o_stall, 0);
    tick();
    chk("lu_issue_valid", o_valid, 1);
    chk("lu_issue_rd", o_rd_addr, 5);
    chk("lu_issue_rs", o_rs_data, 7);
    // A load to r0 is never a hazard
    i_instruction = r_type(5'd0, 5'd1, 5'd5, 6'h20);
    i_ex_mem_read = 1'b1; i_ex_rt_addr = 5'd0; #1;
    chk("lu_r0", o_stall, 0);
    i_ex_mem_read = 1'b0;

    // beq r1,r2,-2 at pc_next 0x100
    i_instruction = i_type(6'd4, 5'd1, 5'd2, 16'hFFFE);
    i_pc_next = 32'h100; i_ctl = 6'b000001; #1;
    chk("beq_sel", o_pc_sel, 1);
    chk("beq_flush", o_flush, 1);
    chk("beq_target", o_pc_target, 32'hF8);
    tick();
    chk("beq_proceeds", o_valid, 1);
    chk("beq_imm", o_imm, 32'hFFFFFFFE);
    chk("beq_opcode", o_opcode, 4);
    i_ctl = 6'b000010; #1;
    chk("bne_sel", o_pc_sel, 0);
    chk("bne_target", o_pc_target, 0);
    // Stalled branch must not redirect
    i_ctl = 6'b000001; i_ex_mem_read = 1'b1; i_ex_rt_addr = 5'd1; #1;
    chk("beq_stalled", o_pc_sel, 0);
    i_ex_mem_read = 1'b0;
    i_valid = 1'b0; #1;
    chk("beq_invalid", o_pc_sel, 0);
    i_valid = 1'b1;

    // jal index 0x40 at pc_next 0x1004
    i_instruction = j_type(6'd3, 26'h40);
    i_pc_next = 32'h1004; i_ctl = 6'b001000; #1;
    chk("jal_sel", o_pc_sel, 1);
    chk("jal_target", o_pc_target, 32'h100);
    tick();
    chk("jal_rd", o_rd_addr, 31);
    chk("jal_link", o_rt_data, 32'h1008);

    // jalr r9, r6 (r6 = 0x2000)
    i_instruction = r_type(5'd6, 5'd0, 5'd9, 6'h09);
    i_pc_next = 32'h500; i_ctl = 6'b100000; #1;
    chk("jalr_target", o_pc_target, 32'h2000);
    chk("jalr_sel", o_pc_sel, 1);
    tick();
    chk("jalr_rd", o_rd_addr, 9);
    chk("jalr_link", o_rt_data, 32'h504);

    // j keeps the upper pc_next bits
    i_instruction = j_type(6'd2, 26'h3);
    i_pc_next = 32'hF000_0000; i_ctl = 6'b000100; #1;
    chk("j_target", o_pc_target, 32'hF000_000C);

    // Debug halt: ID/EX holds jalr, write to r7 suppressed, no redirect or stall
    i_du_halt = 1'b1;
    i_wb_wr_ena = 1'b1; i_wb_addr = 5'd7; i_wb_data = 32'h99;
    i_du_addr = 5'd7;
    i_instruction = r_type(5'd1, 5'd2, 5'd3, 6'h20);
    i_ex_mem_read = 1'b1; i_ex_rt_addr = 5'd1; #1;
    chk("halt_du_old", o_du_data, 32'h77);
    chk("halt_no_sel", o_pc_sel, 0);
    chk("halt_no_stall", o_stall, 0);
    tick();
    chk("halt_hold_rd", o_rd_addr, 9);
    chk("halt_hold_rt", o_rt_data, 32'h504);
    chk("halt_hold_valid", o_valid, 1);
    i_du_halt = 1'b0; i_wb_wr_ena = 1'b0; i_ctl = '0; i_ex_mem_read = 1'b0; #1;
    chk("halt_r7_kept", o_du_data, 32'h77);

    // Reset mid-run with o_valid=1
    tick();
    chk("pre_rst_valid", o_valid, 1);
    i_ex_mem_read = 1'b1; i_ex_rt_addr = 5'd1;
    #2 reset = 1'b0;
    #1;
    chk("midrst_valid", o_valid, 0);
    chk("midrst_rs_data", o_rs_data, 0);
    chk("midrst_rd", o_rd_addr, 0);
    chk("midrst_stall", o_stall, 1);
    reset = 1'b1;
    i_ex_mem_read = 1'b0; i_valid = 1'b0; i_du_addr = 5'd5; #1;
    chk("midrst_r5", o_du_data, 0);

`ifdef ID_BRANCH_FWD_EN
    // r1 is 0 after reset; MEM forwards 5 into r1 so beq r1,r0 is not taken
    i_valid = 1'b1;
    i_mem_wr_ena = 1'b1; i_mem_rd_addr = 5'd1; i_mem_data = 32'd5;
    i_instruction = i_type(6'd4, 5'd1, 5'd0, 16'h0004);
    i_pc_next = 32'h200; i_ctl = 6'b000001; #1;
    chk("fwd_beq_sel", o_pc_sel, 0);
    i_ctl = 6'b000010; #1;
    chk("fwd_bne_sel", o_pc_sel, 1);
    chk("fwd_bne_target", o_pc_target, 32'h210);
    i_ex_wr_ena = 1'b1; i_ex_rd_addr = 5'd1; #1;
    chk("fwd_br_hazard", o_stall, 1);
    i_ctl = '0; #1;
    chk("fwd_no_hazard", o_stall, 0);
    i_mem_wr_ena = 1'b0; i_ex_wr_ena = 1'b0; i_valid = 1'b0;
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
